// File: rtl/int_seq_if.sv
// Port bundle between the interrupt entry sequencer and the surrounding core/controller.
// The optional rfi restore signals exist only when INT_SEQ_RFI_EN is defined.
`ifndef INTOp_WIDTH
`define INTOp_WIDTH 2
`define INTOp_NONE  2'd0
`define INTOp_TRAP  2'd1
`define INTOp_SC    2'd2
`define INTOp_EXT   2'd3
`endif

interface int_seq_if #(
  parameter int PC_WIDTH  = 32,
  parameter int SPR_WIDTH = 32
);
  logic                    int_req;
  logic [`INTOp_WIDTH-1:0] int_op;
  logic                    instr_valid;
  logic [PC_WIDTH-1:0]     pc_cur;
  logic [PC_WIDTH-1:0]     pc_nxt;
  logic [PC_WIDTH-1:0]     int_addr;
  logic [SPR_WIDTH-1:0]    msr;
  logic                    pipe_empty;
  logic                    flush;
  logic                    stall;
  logic                    busy;
  logic                    srr0_we;
  logic [PC_WIDTH-1:0]     srr0_wd;
  logic                    srr1_we;
  logic [SPR_WIDTH-1:0]    srr1_wd;
  logic                    msr_we;
  logic [SPR_WIDTH-1:0]    msr_wd;
  logic                    npc_we;
  logic [PC_WIDTH-1:0]     npc;
  logic                    int_ack;
`ifdef INT_SEQ_RFI_EN
  logic                    rfi;
  logic [PC_WIDTH-1:0]     srr0_q;
  logic [SPR_WIDTH-1:0]    srr1_q;
`endif

  // Core/controller side: drives causes and pipeline status, consumes redirects.
  modport master (
    output int_req, int_op, instr_valid, pc_cur, pc_nxt, int_addr, msr, pipe_empty,
`ifdef INT_SEQ_RFI_EN
    output rfi, srr0_q, srr1_q,
`endif
    input  flush, stall, busy, srr0_we, srr0_wd, srr1_we, srr1_wd,
    input  msr_we, msr_wd, npc_we, npc, int_ack
  );

  // Sequencer side.
  modport slave (
    input  int_req, int_op, instr_valid, pc_cur, pc_nxt, int_addr, msr, pipe_empty,
`ifdef INT_SEQ_RFI_EN
    input  rfi, srr0_q, srr1_q,
`endif
    output flush, stall, busy, srr0_we, srr0_wd, srr1_we, srr1_wd,
    output msr_we, msr_wd, npc_we, npc, int_ack
  );
endinterface

// File: rtl/int_seq.sv
// Interrupt entry sequencer: drain the pipe, save SRR0/SRR1, clear MSR[EE], redirect to the vector.
// Optional macro INT_SEQ_RFI_EN adds a one-cycle return-from-interrupt restore state.
module int_seq #(
  parameter int PC_WIDTH  = 32,
  parameter int SPR_WIDTH = 32,
  parameter int EE_BIT    = 16
) (
  input logic     clk,
  input logic     rst,
  int_seq_if.slave bus
);

  // EE_BIT is big-endian numbered; convert to a little-endian vector index.
  localparam int EE_IDX = SPR_WIDTH - 1 - EE_BIT;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_SAVE,
    S_VECTOR
`ifdef INT_SEQ_RFI_EN
    , S_RFI
`endif
  } state_t;

  state_t               state_q, state_d;
  logic [PC_WIDTH-1:0]  ret_addr_q, ret_addr_d;
  logic [SPR_WIDTH-1:0] saved_msr_q, saved_msr_d;
  logic                 is_async_q, is_async_d;
  logic                 first_q, first_d;

  logic                 sync_evt;
  logic                 async_evt;

  logic                 flush, stall, busy;
  logic                 srr0_we, srr1_we, msr_we, npc_we, int_ack;
  logic [PC_WIDTH-1:0]  srr0_wd, npc;
  logic [SPR_WIDTH-1:0] srr1_wd, msr_wd;

  function automatic logic [SPR_WIDTH-1:0] clr_ee(input logic [SPR_WIDTH-1:0] v);
    logic [SPR_WIDTH-1:0] r;
    r         = v;
    r[EE_IDX] = 1'b0;
    return r;
  endfunction

  assign sync_evt  = bus.instr_valid &&
                     ((bus.int_op == `INTOp_TRAP) || (bus.int_op == `INTOp_SC) ||
                      (bus.int_op == `INTOp_EXT));
  assign async_evt = bus.int_req && bus.msr[EE_IDX];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ret_addr_q  <= '0;
      saved_msr_q <= '0;
      is_async_q  <= 1'b0;
      first_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_addr_q  <= ret_addr_d;
      saved_msr_q <= saved_msr_d;
      is_async_q  <= is_async_d;
      first_q     <= first_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ret_addr_d  = ret_addr_q;
    saved_msr_d = saved_msr_q;
    is_async_d  = is_async_q;
    first_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
`ifdef INT_SEQ_RFI_EN
        if (bus.instr_valid && bus.rfi) begin
          state_d = S_RFI;
        end else
`endif
        // Sync causes win; a coincident async request stays latched upstream.
        if (sync_evt) begin
          ret_addr_d  = (bus.int_op == `INTOp_TRAP) ? bus.pc_cur : bus.pc_cur + PC_WIDTH'(4);
          saved_msr_d = bus.msr;
          is_async_d  = 1'b0;
          first_d     = 1'b1;
          state_d     = S_DRAIN;
        end else if (async_evt) begin
          ret_addr_d  = bus.pc_nxt;
          saved_msr_d = bus.msr;
          is_async_d  = 1'b1;
          first_d     = 1'b1;
          state_d     = S_DRAIN;
        end
      end
      S_DRAIN:  if (bus.pipe_empty) state_d = S_SAVE;
      S_SAVE:   state_d = S_VECTOR;
      S_VECTOR: state_d = S_IDLE;
`ifdef INT_SEQ_RFI_EN
      S_RFI:    state_d = S_IDLE;
`endif
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    flush   = 1'b0;
    stall   = 1'b0;
    busy    = (state_q != S_IDLE);
    srr0_we = 1'b0;
    srr0_wd = '0;
    srr1_we = 1'b0;
    srr1_wd = '0;
    msr_we  = 1'b0;
    msr_wd  = '0;
    npc_we  = 1'b0;
    npc     = '0;
    int_ack = 1'b0;
    case (state_q)
      S_DRAIN: begin
        flush = first_q;
        stall = 1'b1;
      end
      S_SAVE: begin
        stall   = 1'b1;
        srr0_we = 1'b1;
        srr0_wd = ret_addr_q;
        srr1_we = 1'b1;
        srr1_wd = saved_msr_q;
        msr_we  = 1'b1;
        msr_wd  = clr_ee(saved_msr_q);
      end
      S_VECTOR: begin
        stall   = 1'b1;
        npc_we  = 1'b1;
        npc     = bus.int_addr;
        int_ack = is_async_q;
      end
`ifdef INT_SEQ_RFI_EN
      S_RFI: begin
        flush  = 1'b1;
        stall  = 1'b1;
        msr_we = 1'b1;
        msr_wd = bus.srr1_q;
        npc_we = 1'b1;
        npc    = bus.srr0_q;
      end
`endif
      default: ;
    endcase
  end

  assign bus.flush   = flush;
  assign bus.stall   = stall;
  assign bus.busy    = busy;
  assign bus.srr0_we = srr0_we;
  assign bus.srr0_wd = srr0_wd;
  assign bus.srr1_we = srr1_we;
  assign bus.srr1_wd = srr1_wd;
  assign bus.msr_we  = msr_we;
  assign bus.msr_wd  = msr_wd;
  assign bus.npc_we  = npc_we;
  assign bus.npc     = npc;
  assign bus.int_ack = int_ack;

endmodule

// File: doc/int_seq.md
Name: int_seq

Overview:
Interrupt entry sequencer. It sits directly downstream of the interrupt controller (request latch, vector entry and intOp encoder) and consumes its intReq, intAddr and intOp outputs. On a synchronous (trap/sc/intr instruction) or enabled asynchronous event, it flushes and drains the pipe, saves the return state into SRR0/SRR1, clears MSR[EE], and redirects fetch to the vector. It returns intAck to the controller's request latch for asynchronous events only.

Parameters:
PC_WIDTH, 32, width of the PC, return address and vector.
SPR_WIDTH, 32, width of MSR/SRR0/SRR1.
EE_BIT, 16, MSR[EE] position in big-endian [0:SPR_WIDTH-1] numbering.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
int_req  in  1  pending async request from the controller's request latch (intReq).
int_op  in  `INTOp_WIDTH  encoded cause of the EX instruction (INTOp_NONE/TRAP/SC/EXT).
instr_valid  in  1  EX instruction is valid; qualifies int_op.
pc_cur  in  PC_WIDTH  address of the EX instruction.
pc_nxt  in  PC_WIDTH  address of the next unexecuted instruction (async return point).
int_addr  in  PC_WIDTH  vector address from the entry logic (intAddr).
msr  in  SPR_WIDTH  current MSR.
pipe_empty  in  1  downstream stages drained, no pending writeback.
flush  out  1  kill younger instructions.
stall  out  1  freeze fetch/decode.
busy  out  1  sequencer not IDLE.
srr0_we / srr0_wd  out  1 / PC_WIDTH  SRR0 write.
srr1_we / srr1_wd  out  1 / SPR_WIDTH  SRR1 write.
msr_we / msr_wd  out  1 / SPR_WIDTH  MSR write.
npc_we / npc  out  1 / PC_WIDTH  PC redirect.
int_ack  out  1  clears the controller's request latch (intAck).

Behaviour:
- FSM states: IDLE, DRAIN, SAVE, VECTOR. All outputs are Moore, decoded from registered state and capture registers.
- Reset (any time, including mid-sequence): state goes to IDLE; capture registers clear; every output is 0.
- IDLE, priority on each edge:
  - (1) sync: instr_valid and int_op is TRAP, SC or EXT.
  - (2) async: int_req and msr[EE_BIT].
  - (3) otherwise stay in IDLE.
- On (1) or (2), capture the following, then go to DRAIN:
  - ret_addr: pc_cur for TRAP; pc_cur+4 (mod 2^PC_WIDTH) for SC/EXT; pc_nxt for async.
  - saved_msr = msr.
  - is_async flag.
- If sync and async are both present on the same edge, sync is taken. The async request stays pending in the controller's latch and is re-evaluated in IDLE.
- DRAIN:
  - flush=1 in the first DRAIN cycle only.
  - stall=1.
  - Advance to SAVE on the first edge where pipe_empty=1. There is no timeout.
- SAVE (1 cycle): stall=1 and
  - srr0_we=1, srr0_wd=ret_addr.
  - srr1_we=1, srr1_wd=saved_msr.
  - msr_we=1, msr_wd=saved_msr with bit EE_BIT cleared.
  - Then go to VECTOR.
- VECTOR (1 cycle): stall=1; npc_we=1, npc=int_addr; int_ack=is_async. Then go to IDLE.
- busy=1 in every state except IDLE.
- Latency: detection edge E. With pipe_empty already 1, DRAIN is cycle E+1 (flush), SAVE is E+2, VECTOR is E+3 (npc_we, int_ack), and IDLE resumes at E+4.
- int_req dropping after capture does not abort the sequence. int_req or int_op arriving while busy are ignored until IDLE.
- int_ack is exactly one cycle wide and is never asserted for sync causes.

Optional Feature:
INT_SEQ_RFI_EN
- Enabled:
  - Adds ports: rfi (in, 1), srr0_q (in, PC_WIDTH), srr1_q (in, SPR_WIDTH).
  - In IDLE, instr_valid & rfi has priority over both sync and async events and enters state RFI for 1 cycle.
  - In RFI: flush=1, stall=1, msr_we=1, msr_wd=srr1_q, npc_we=1, npc=srr0_q; int_ack=0. Then return to IDLE.
- Disabled: the extra ports and the RFI state do not exist; rfi-class instructions get no restore from this block.

Test Plan:
- Reset mid-sequence: rst=1 while in SAVE -> all outputs 0 the same cycle; IDLE after release with no SRR writes.
- Async: msr=0x00008000, int_req=1, pipe_empty=1, pc_nxt=0x1008, int_addr=0x500 -> flush at E+1; at E+2 srr0=0x1008, srr1=0x00008000, msr_wd=0x00000000; at E+3 npc=0x500 with int_ack=1 for one cycle.
- EE masked: msr=0, int_req=1 held 20 cycles -> busy stays 0, no outputs.
- SC with slow drain: int_op=SC, pc_cur=0x2000, pipe_empty low for 3 cycles -> flush 1 cycle, stall held, srr0_wd=0x2004, int_ack=0.
- Simultaneous TRAP and async, pc_cur=0xFFFFFFFC -> TRAP serviced first with srr0=0xFFFFFFFC. After IDLE, msr[EE]=0 (from the SAVE) so async is not taken. Separately, SC at 0xFFFFFFFC -> srr0_wd wraps to 0x00000000.
- INT_SEQ_RFI_EN defined: rfi=1, srr0_q=0x1008, srr1_q=0x00008000 -> one cycle with npc=0x1008, msr_wd=0x00008000, flush=1. Pending int_req is then taken on the next IDLE edge.
